// File: rtl/instr_fetch_queue.sv
// Decoupled fetch stage: owns the fetch PC, issues in-order requests to a variable-latency
// instruction memory and buffers returned words with their PCs for the IF/ID register.
module instr_fetch_queue #(
  parameter int PC_W    = 9,
  parameter int INS_W   = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  output logic                     imem_req,
  output logic [PC_W-1:0]          imem_addr,
  input  logic                     imem_ready,
  input  logic                     imem_rvalid,
  input  logic [INS_W-1:0]         imem_rdata,
  output logic                     if_valid,
  output logic [PC_W-1:0]          if_pc,
  output logic [INS_W-1:0]         if_instr,
  input  logic                     if_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);
  localparam logic [SUM_W-1:0] DEPTH_C   = SUM_W'(DEPTH);
  localparam logic [PC_W-1:0]  PC_STEP   = PC_W'(4);

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d, discard_q, discard_d;
  logic [PC_W-1:0]  pc_mem_q [DEPTH];
  logic [PC_W-1:0]  pc_mem_d [DEPTH];
  logic [INS_W-1:0] instr_mem_q [DEPTH];
  logic [INS_W-1:0] instr_mem_d [DEPTH];
  logic [SUM_W-1:0] reserved;
  logic [PC_W-1:0]  target_pc;
  logic             accept, resp_ok, push, pop;
  logic             unused_pc_lsbs;

  assign target_pc      = {redirect_pc[PC_W-1:2], 2'b00};
  assign unused_pc_lsbs = ^redirect_pc[1:0];

  // In-flight requests hold a FIFO slot each, so a returning word always has room.
  assign reserved  = SUM_W'(count_q) + SUM_W'(outstanding_q);
  assign imem_req  = !reset && !redirect && (outstanding_q < MAX_OUT_C) && (reserved < DEPTH_C);
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok   = imem_rvalid && (outstanding_q != '0);
  assign push      = resp_ok && !redirect && (discard_q == '0);

  assign if_valid  = (count_q != '0);
  assign pop       = if_valid && if_ready && !redirect;
  assign if_pc     = if_valid ? pc_mem_q[head_q] : '0;
  assign if_instr  = if_valid ? instr_mem_q[head_q] : '0;
  assign occupancy = count_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    discard_d     = discard_q;
    pc_mem_d      = pc_mem_q;
    instr_mem_d   = instr_mem_q;
    outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(resp_ok);
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);

    if (accept) fetch_pc_d = fetch_pc_q + PC_STEP;

    if (push) begin
      pc_mem_d[tail_q]    = resp_pc_q;
      instr_mem_d[tail_q] = imem_rdata;
      tail_d              = tail_q + 1'b1;
      resp_pc_d           = resp_pc_q + PC_STEP;
    end

    if (pop) head_d = head_q + 1'b1;

    if (resp_ok && (discard_q != '0)) discard_d = discard_q - 1'b1;

    // Everything still in flight after this edge predates the redirect and must be dropped.
    if (redirect) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      discard_d  = outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= '0;
      resp_pc_q     <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      pc_mem_q      <= pc_mem_d;
      instr_mem_q   <= instr_mem_d;
    end
  end

  rvalid_has_outstanding: assert property (@(posedge clk) disable iff (reset)
    imem_rvalid |-> (outstanding_q != '0));

endmodule
